// File: rtl/alu_rs_pkg.sv
// Shared types and helpers for the ALU reservation station.
// Define ALU_RS_SLT_EN to add the signed set-less-than op (2-bit stored op field).
package alu_rs_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SLT = 2'b10,
    OP_RSV = 2'b11
  } alu_op_e;

`ifdef ALU_RS_SLT_EN
  typedef logic [1:0] op_store_t;
`else
  typedef logic [0:0] op_store_t;
`endif

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [DATA_W-1:0]    data;
  } opd_t;

  typedef struct packed {
    logic                 valid;
    op_store_t            op;
    logic [ROB_WIDTH-1:0] tag;
    logic [1:0]           scale;
    opd_t                 opd0;
    opd_t                 opd1;
  } alu_rs_entry_t;

  function automatic logic tag_match(input opd_t o, input logic cdb_valid,
                                     input logic [ROB_WIDTH-1:0] cdb_tag);
    return !o.valid && cdb_valid && (o.tag == cdb_tag);
  endfunction

  // A waiting operand captures the broadcast value, pre-shifted by its scale.
  function automatic opd_t wake_opd(input opd_t o, input logic cv,
                                    input logic [ROB_WIDTH-1:0] ct,
                                    input logic [DATA_W-1:0] cd, input logic [1:0] sh);
    opd_t r;
    if (tag_match(o, cv, ct)) begin
      r       = o;
      r.valid = 1'b1;
      r.data  = cd << sh;
    end else begin
      r = o;
    end
    return r;
  endfunction

  // Reserved or disabled encodings collapse to ADD.
  function automatic op_store_t encode_op(input logic [1:0] op);
    op_store_t r;
`ifdef ALU_RS_SLT_EN
    case (alu_op_e'(op))
      OP_SUB:  r = 2'b01;
      OP_SLT:  r = 2'b10;
      default: r = 2'b00;
    endcase
`else
    case (alu_op_e'(op))
      OP_SUB:  r = 1'b1;
      default: r = 1'b0;
    endcase
`endif
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] alu_calc(input op_store_t op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
`ifdef ALU_RS_SLT_EN
    case (op)
      2'b01:   r = a - b;
      2'b10:   r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = a + b;
    endcase
`else
    if (op[0]) begin
      r = a - b;
    end else begin
      r = a + b;
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_chk.sv
// Input checker for the ALU reservation station: flags op encodings
// the current build (ALU_RS_SLT_EN or not) cannot execute.
module alu_rs_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       in_valid,
  input logic [1:0] in_op
);

`ifdef ALU_RS_SLT_EN
  localparam logic [1:0] MAX_OP = 2'b10;
`else
  localparam logic [1:0] MAX_OP = 2'b01;
`endif

  a_legal_op: assert property (@(posedge clk) disable iff (!rst_n)
                               in_valid |-> (in_op <= MAX_OP))
    else $error("alu_rs: illegal in_op %0b", in_op);

endmodule

// File: rtl/alu_rs_select.sv
// Oldest-ready picker: isolates the lowest set bit of the ready vector
// and reports it both one-hot and as a binary index.
module alu_rs_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     ready_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [N-1:0] grant_s;

  // Two's-complement trick keeps only the lowest ready bit.
  always_comb begin
    grant_s = ready_i & (~ready_i + N'(1));
    idx_o   = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_o = idx_o | (grant_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

  assign grant_o = grant_s;
  assign any_o   = |ready_i;

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: compacting queue (slot 0 oldest), CDB wakeup,
// oldest-ready issue, registered result. ALU_RS_SLT_EN adds signed SLT.
// Tag and data widths are the shared package constants ROB_WIDTH / DATA_W.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int N_ENTRY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [1:0]             in_scale,
  input  logic [ROB_WIDTH-1:0]   in_tag,
  input  logic [1:0]             in_opd_valid,
  input  logic [2*ROB_WIDTH-1:0] in_opd_tag,
  input  logic [2*DATA_W-1:0]    in_opd_data,
  input  logic                   cdb_valid,
  input  logic [ROB_WIDTH-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]      cdb_data,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic                   res_valid,
  output logic [ROB_WIDTH-1:0]   res_tag,
  output logic [DATA_W-1:0]      res_data
);

  localparam int IDX_W = $clog2(N_ENTRY);
  localparam int CNT_W = $clog2(N_ENTRY + 1);

  alu_rs_entry_t        entry_q [N_ENTRY];
  alu_rs_entry_t        entry_d [N_ENTRY];
  alu_rs_entry_t        woken_s [N_ENTRY+1];
  alu_rs_entry_t        new_s;
  logic [CNT_W-1:0]     count_q, count_d, cnt_after_s;
  logic [N_ENTRY-1:0]   ready_s, grant_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 sel_any_s, issue_s, enq_s;
  op_store_t            sel_op_s;
  logic [ROB_WIDTH-1:0] sel_tag_s;
  logic [DATA_W-1:0]    sel_a_s, sel_b_s;
  logic                 res_valid_q;
  logic [ROB_WIDTH-1:0] res_tag_q;
  logic [DATA_W-1:0]    res_data_q;

  // Readiness uses registered operand state only, so a CDB hit issues a cycle later.
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      ready_s[i] = entry_q[i].valid && entry_q[i].opd0.valid && entry_q[i].opd1.valid;
    end
  end

  alu_rs_select #(.N(N_ENTRY), .IDX_W(IDX_W)) u_select (
    .ready_i (ready_s),
    .grant_o (grant_s),
    .idx_o   (sel_idx_s),
    .any_o   (sel_any_s)
  );

  assign req_valid = sel_any_s;
  assign issue_s   = sel_any_s && req_ready && !flush;
  assign in_ready  = (count_q < CNT_W'(N_ENTRY)) || issue_s;
  assign enq_s     = in_valid && in_ready && !flush;

  // One-hot mux of the granted entry's execution fields.
  always_comb begin
    sel_op_s  = '0;
    sel_tag_s = '0;
    sel_a_s   = '0;
    sel_b_s   = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      sel_op_s  = sel_op_s  | (entry_q[i].op        & {$bits(op_store_t){grant_s[i]}});
      sel_tag_s = sel_tag_s | (entry_q[i].tag       & {ROB_WIDTH{grant_s[i]}});
      sel_a_s   = sel_a_s   | (entry_q[i].opd0.data & {DATA_W{grant_s[i]}});
      sel_b_s   = sel_b_s   | (entry_q[i].opd1.data & {DATA_W{grant_s[i]}});
    end
  end

  // Incoming op, including same-cycle wakeup; opd[1] is stored pre-scaled.
  always_comb begin
    new_s            = '0;
    new_s.valid      = 1'b1;
    new_s.op         = encode_op(in_op);
    new_s.tag        = in_tag;
    new_s.scale      = in_scale;
    new_s.opd0.valid = in_opd_valid[0];
    new_s.opd0.tag   = in_opd_tag[ROB_WIDTH-1:0];
    new_s.opd0.data  = in_opd_data[DATA_W-1:0];
    new_s.opd1.valid = in_opd_valid[1];
    new_s.opd1.tag   = in_opd_tag[2*ROB_WIDTH-1:ROB_WIDTH];
    new_s.opd1.data  = in_opd_data[2*DATA_W-1:DATA_W] << in_scale;
    new_s.opd0       = wake_opd(new_s.opd0, cdb_valid, cdb_tag, cdb_data, 2'd0);
    new_s.opd1       = wake_opd(new_s.opd1, cdb_valid, cdb_tag, cdb_data, in_scale);
  end

  // Next queue: wakeup, remove issued slot by shifting younger down, append, flush.
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      woken_s[i]      = entry_q[i];
      woken_s[i].opd0 = wake_opd(entry_q[i].opd0, cdb_valid, cdb_tag, cdb_data, 2'd0);
      woken_s[i].opd1 = wake_opd(entry_q[i].opd1, cdb_valid, cdb_tag, cdb_data,
                                 entry_q[i].scale);
    end
    woken_s[N_ENTRY] = '0;
    cnt_after_s = count_q - {{(CNT_W-1){1'b0}}, issue_s};
    for (int i = 0; i < N_ENTRY; i++) begin
      if (flush) begin
        entry_d[i] = '0;
      end else if (enq_s && (CNT_W'(i) == cnt_after_s)) begin
        entry_d[i] = new_s;
      end else if (issue_s && (IDX_W'(i) >= sel_idx_s)) begin
        entry_d[i] = woken_s[i+1];
      end else begin
        entry_d[i] = woken_s[i];
      end
    end
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = cnt_after_s + {{(CNT_W-1){1'b0}}, enq_s};
    end
  end

  // Queue state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        entry_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) begin
        entry_q[i] <= entry_d[i];
      end
      count_q <= count_d;
    end
  end

  // Result register: tag/data hold when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else if (issue_s) begin
      res_valid_q <= 1'b1;
      res_tag_q   <= sel_tag_s;
      res_data_q  <= alu_calc(sel_op_s, sel_a_s, sel_b_s);
    end else begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_data  = res_data_q;

  alu_rs_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_op    (in_op)
  );

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a queue-based reference model predicts issue order
// and results; a monitor process pops expectations whenever res_valid is seen.
module tb_alu_rs;

  localparam int N = 4;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic        in_ready, req_valid, res_valid;
  logic [1:0]  in_op = 2'b00, in_scale = 2'b00, in_opd_valid = 2'b00;
  logic [3:0]  in_tag = 4'd0, cdb_tag = 4'd0, res_tag;
  logic [7:0]  in_opd_tag = 8'd0;
  logic [63:0] in_opd_data = 64'd0;
  logic        cdb_valid = 1'b0, req_ready = 1'b0;
  logic [31:0] cdb_data = 32'd0, res_data;

  alu_rs #(.N_ENTRY(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_scale(in_scale), .in_tag(in_tag), .in_opd_valid(in_opd_valid),
    .in_opd_tag(in_opd_tag), .in_opd_data(in_opd_data), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .req_valid(req_valid), .req_ready(req_ready),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [3:0]  tag;
    int          sc;
    bit          av;
    logic [3:0]  at;
    logic [31:0] a;
    bit          bv;
    logic [3:0]  bt;
    logic [31:0] b;
  } ment_t;
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } res_t;

  ment_t       mq[$];
  res_t        sb[$];
  res_t        mon_r;
  int          n_cmp = 0, n_bad = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  last_tag = 4'd0;
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_calc(input int op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      1:       return a - b;
      2:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  // One cycle: apply inputs, check handshake outputs, advance the reference queue.
  task automatic drive(input bit iv, input int op, input int sc, input logic [3:0] tg,
                       input bit v0, input logic [3:0] t0, input logic [31:0] d0,
                       input bit v1, input logic [3:0] t1, input logic [31:0] d1,
                       input bit cv, input logic [3:0] ct, input logic [31:0] cd,
                       input bit rr, input bit fl);
    int    sel;
    bit    exp_iss, exp_inr;
    ment_t e;
    res_t  r;
    @(negedge clk);
    in_valid = iv; in_op = 2'(op); in_scale = 2'(sc); in_tag = tg;
    in_opd_valid = {v1, v0}; in_opd_tag = {t1, t0}; in_opd_data = {d1, d0};
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd; req_ready = rr; flush = fl;
    #1;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].av && mq[i].bv) sel = i;
    exp_iss = (sel >= 0) && rr && !fl;
    exp_inr = (mq.size() < N) || exp_iss;
    chk("req_valid", 32'(req_valid), 32'(sel >= 0));
    chk("in_ready", 32'(in_ready), 32'(exp_inr));
    if (exp_iss) begin
      r.tag  = mq[sel].tag;
      r.data = ref_calc(mq[sel].op, mq[sel].a, mq[sel].b);
      sb.push_back(r);
      mq.delete(sel);
    end
    foreach (mq[i]) begin
      if (!mq[i].av && cv && mq[i].at == ct) begin mq[i].av = 1'b1; mq[i].a = cd; end
      if (!mq[i].bv && cv && mq[i].bt == ct) begin
        mq[i].bv = 1'b1; mq[i].b = cd * (32'd1 << mq[i].sc);
      end
    end
    if (iv && exp_inr && !fl) begin
      e.op = op; e.tag = tg; e.sc = sc;
      e.av = v0; e.at = t0; e.a = d0;
      e.bv = v1; e.bt = t1; e.b = d1 * (32'd1 << sc);
      if (!e.av && cv && e.at == ct) begin e.av = 1'b1; e.a = cd; end
      if (!e.bv && cv && e.bt == ct) begin e.bv = 1'b1; e.b = cd * (32'd1 << sc); end
      mq.push_back(e);
    end
    if (fl) mq.delete();
  endtask

  task automatic idle(input bit rr);
    drive(0, 0, 0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, rr, 0);
  endtask

  task automatic cdb(input logic [3:0] ct, input logic [31:0] cd, input bit rr);
    drive(0, 0, 0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, ct, cd, rr, 0);
  endtask

  task automatic enq_ready(input int op, input logic [3:0] tg, input logic [31:0] a,
                           input logic [31:0] b, input bit rr);
    drive(1, op, 0, tg, 1, 4'd0, a, 1, 4'd0, b, 0, 4'd0, 32'd0, rr, 0);
  endtask

  task automatic enq_wait1(input logic [3:0] tg, input logic [31:0] a,
                           input logic [3:0] wt, input int sc, input int op);
    drive(1, op, sc, tg, 1, 4'd0, a, 0, wt, 32'hDEAD_BEEF, 0, 4'd0, 32'd0, 0, 0);
  endtask

  task automatic chk_result(input string nm, input logic [3:0] tg, input logic [31:0] d);
    @(posedge clk);
    #3;
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_tag"}, 32'(res_tag), 32'(tg));
    chk({nm, "_data"}, res_data, d);
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL res_unexpected: res_valid=1 tag %0h required res_valid=0", res_tag);
        end else begin
          mon_r = sb.pop_front();
          chk("res_tag", 32'(res_tag), 32'(mon_r.tag));
          chk("res_data", res_data, mon_r.data);
          last_tag  = mon_r.tag;
          last_data = mon_r.data;
        end
      end else begin
        chk("res_tag_hold", 32'(res_tag), 32'(last_tag));
        chk("res_data_hold", res_data, last_data);
        if (sb.size() != 0) begin
          n_cmp++; n_bad++;
          $display("FAIL res_missing: res_valid=0 required 1 (tag %0h)", sb[0].tag);
          sb.delete();
        end
      end
    end
  end

  initial begin
    logic [3:0] pt[$];
    logic [3:0] ct;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    mon_en = 1'b1;

    // ADD 5+7, tag 3
    enq_ready(0, 4'd3, 32'd5, 32'd7, 1);
    idle(1);
    chk_result("t2", 4'd3, 32'd12);

    // SUB 100 - (4<<2) with opd[1] woken by tag 9
    enq_wait1(4'd5, 32'd100, 4'd9, 2, 1);
    cdb(4'd9, 32'd4, 1);
    idle(1);
    chk_result("t3", 4'd5, 32'd84);

    // Fill with unready ops, then wake only slot 2
    for (int i = 0; i < N; i++) enq_wait1(4'(i + 1), 32'(10 * i), 4'(10 + i), 0, 0);
    drive(1, 0, 0, 4'd7, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1, 0, 4'd0, 32'd0, 0, 0);
    chk("t4_full_in_ready", 32'(in_ready), 32'd0);
    cdb(4'd12, 32'd5, 0);
    idle(1);
    chk("t4_issue_in_ready", 32'(in_ready), 32'd1);
    chk_result("t4", 4'd3, 32'd25);
    cdb(4'd13, 32'd1, 1);
    cdb(4'd10, 32'd2, 1);
    cdb(4'd11, 32'd3, 1);
    repeat (4) idle(1);

    // Two ready oldest entries; issue + enqueue while full
    enq_ready(0, 4'd1, 32'd1, 32'd2, 0);
    enq_ready(1, 4'd2, 32'd3, 32'd4, 0);
    enq_wait1(4'd8, 32'd6, 4'd14, 0, 0);
    enq_wait1(4'd9, 32'd7, 4'd15, 1, 0);
    enq_ready(0, 4'd6, 32'd5, 32'd5, 1);
    chk("t5_full_issue_in_ready", 32'(in_ready), 32'd1);
    chk_result("t5a", 4'd1, 32'd3);
    idle(1);
    chk_result("t5b", 4'd2, 32'hFFFF_FFFF);
    cdb(4'd14, 32'd1, 1);
    cdb(4'd15, 32'd1, 1);
    repeat (4) idle(1);

    // Flush with 3 entries plus an enqueue offer
    enq_ready(0, 4'd1, 32'd1, 32'd1, 0);
    enq_ready(1, 4'd2, 32'd9, 32'd1, 0);
    enq_wait1(4'd3, 32'd1, 4'd11, 0, 0);
    drive(1, 0, 0, 4'd4, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1, 0, 4'd0, 32'd0, 1, 1);
    idle(1);
    chk("t6_req_valid", 32'(req_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);

`ifdef ALU_RS_SLT_EN
    enq_ready(2, 4'd2, 32'hFFFF_FFFF, 32'd1, 0);
    idle(1);
    chk_result("slt", 4'd2, 32'd1);
`endif

    // Randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      pt.delete();
      foreach (mq[i]) begin
        if (!mq[i].av) pt.push_back(mq[i].at);
        if (!mq[i].bv) pt.push_back(mq[i].bt);
      end
      if (pt.size() > 0 && $urandom_range(0, 3) != 0) ct = pt[$urandom_range(0, pt.size() - 1)];
      else ct = 4'($urandom);
`ifdef ALU_RS_SLT_EN
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 3),
`else
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
`endif
            4'($urandom), $urandom_range(0, 2) != 0, 4'($urandom), $urandom,
            $urandom_range(0, 2) != 0, 4'($urandom), $urandom,
            $urandom_range(0, 1) == 1, ct, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      if (c == 1500) begin
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res_tag", 32'(res_tag), 32'd0);
        chk("mid_rst_res_data", res_data, 32'd0);
        chk("mid_rst_req_valid", 32'(req_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        mq.delete();
        sb.delete();
        last_tag  = 4'd0;
        last_data = 32'd0;
        in_valid = 1'b0; cdb_valid = 1'b0; req_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
      end
    end

    repeat (6) idle(1);
    @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
